// File: rtl/hs32_aict_pkg.sv
// hs32_aict_pkg
// Shared definitions for the AICT interrupt controller:
//   - FSM state encoding
//   - window-relative register offsets
//   - entry register field positions and the entry read-back helper
package hs32_aict_pkg;

    // Controller FSM states: no request, request presented, interrupt in service
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } aict_state_e;

    // Byte offsets of the control registers inside the AICT window
    localparam logic [7:0] OFF_PENDING = 8'h70;
    localparam logic [7:0] OFF_STATUS  = 8'h74;
    localparam logic [7:0] OFF_EOI     = 8'h78;

    // Entry register fields
    localparam int ENTRY_EN_BIT  = 0;
    localparam int ENTRY_HND_LSB = 2;
    localparam int ENTRY_HND_MSB = 31;
    localparam int ENTRY_HND_W   = ENTRY_HND_MSB - ENTRY_HND_LSB + 1;

    // Width of the vector / line-number field
    localparam int VEC_W = 5;

    // Read-back view of an entry: bit1 is not stored and always reads 0
    function automatic logic [31:0] entry_word(input logic en, input logic [ENTRY_HND_W-1:0] hnd);
        return {hnd, 1'b0, en};
    endfunction

    // Handler address presented to the core: word aligned
    function automatic logic [31:0] handler_addr(input logic [ENTRY_HND_W-1:0] hnd);
        return {hnd, 2'b00};
    endfunction

endpackage

// File: rtl/hs32_aict_if.sv
// hs32_aict_if
// Device-slot bus between the interconnect (master) and the AICT (slave).
//   i_stb  : strobe, held by the master until o_ack
//   i_addr : window-relative byte offset (bits [1:0] ignored by the slave)
//   i_rw   : 1 = write, 0 = read
//   i_dtw  : write data
//   o_ack  : one-cycle acknowledge
//   o_dtr  : read data, valid while o_ack is high
interface hs32_aict_if #(
    parameter int MASK_LEN = 8
);
    logic                i_stb;
    logic [MASK_LEN-1:0] i_addr;
    logic                i_rw;
    logic [31:0]         i_dtw;
    logic                o_ack;
    logic [31:0]         o_dtr;

    modport master (
        output i_stb,
        output i_addr,
        output i_rw,
        output i_dtw,
        input  o_ack,
        input  o_dtr
    );

    modport slave (
        input  i_stb,
        input  i_addr,
        input  i_rw,
        input  i_dtw,
        output o_ack,
        output o_dtr
    );
endinterface

// File: rtl/hs32_aict_prio.sv
// hs32_aict_prio
// Combinational lowest-index-wins priority encoder.
//   req   : request vector (N bits, N <= 32)
//   valid : at least one request bit set
//   idx   : index of the lowest set request bit (0 when none)
module hs32_aict_prio
    import hs32_aict_pkg::*;
#(
    parameter int N = 24
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [VEC_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one to land in idx
    always_comb begin
        valid = 1'b0;
        idx   = {VEC_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            valid = valid | req[i];
            idx   = req[i] ? VEC_W'(i) : idx;
        end
    end

endmodule

// File: rtl/hs32_aict.sv
// hs32_aict
// Advanced interrupt controller table device for the hs32 core.
// Holds NIRQ handler entries, latches rising interrupt edges into a pending
// register, presents the highest-priority enabled pending line to the core
// and tracks a single in-service interrupt until EOI is written.
// Ports:
//   clk       : clock, all state on its rising edge
//   reset     : asynchronous active-low reset
//   bus       : device-slot bus (slave modport)
//   i_irq     : interrupt lines, synchronous to clk
//   o_int     : interrupt request to the core
//   o_vec     : line number of the request
//   o_handler : handler address of the request
//   i_iack    : core accepts the request (one-cycle pulse)
module hs32_aict
    import hs32_aict_pkg::*;
#(
    parameter int NIRQ     = 24,
    parameter int MASK_LEN = 8
) (
    input  logic             clk,
    input  logic             reset,
    hs32_aict_if.slave       bus,
    input  logic [NIRQ-1:0]  i_irq,
    output logic             o_int,
    output logic [VEC_W-1:0] o_vec,
    output logic [31:0]      o_handler,
    input  logic             i_iack
);

    localparam int WORD_W = MASK_LEN - 2;

    // Register offsets resized to the window width, then reduced to word addresses
    localparam logic [MASK_LEN-1:0] OFF_PEND_A = MASK_LEN'(OFF_PENDING);
    localparam logic [MASK_LEN-1:0] OFF_STAT_A = MASK_LEN'(OFF_STATUS);
    localparam logic [MASK_LEN-1:0] OFF_EOI_A  = MASK_LEN'(OFF_EOI);
    localparam logic [WORD_W-1:0]   W_PEND     = OFF_PEND_A[MASK_LEN-1:2];
    localparam logic [WORD_W-1:0]   W_STAT     = OFF_STAT_A[MASK_LEN-1:2];
    localparam logic [WORD_W-1:0]   W_EOI      = OFF_EOI_A[MASK_LEN-1:2];

    // Registered state
    logic                   ack_r;
    logic [31:0]            dtr_r;
    logic [NIRQ-1:0]        en_r;
    logic [ENTRY_HND_W-1:0] hnd_r [NIRQ];
    logic [NIRQ-1:0]        pending_r;
    logic [NIRQ-1:0]        irq_q_r;
    aict_state_e            state_r;
    logic                   int_r;
    logic [VEC_W-1:0]       vec_r;
    logic [31:0]            handler_r;

    // Bus decode
    logic                   access_s;
    logic                   wr_s;
    logic                   rd_s;
    logic [WORD_W-1:0]      word_s;
    logic                   hit_pend_s;
    logic                   hit_stat_s;
    logic                   hit_eoi_s;
    logic [NIRQ-1:0]        entry_wr_s;
    logic [31:0]            entry_rdata_s;
    logic [31:0]            rdata_s;

    // Capture / arbitration
    logic [NIRQ-1:0]        rise_s;
    logic [NIRQ-1:0]        clr_s;
    logic [NIRQ-1:0]        ack_clr_s;
    logic [NIRQ-1:0]        pending_nxt_s;
    logic [NIRQ-1:0]        active_s;
    logic                   win_valid_s;
    logic [VEC_W-1:0]       win_idx_s;
    logic [ENTRY_HND_W-1:0] win_hnd_s;
    logic [ENTRY_HND_W-1:0] cur_hnd_s;
    logic [31:0]            pend_ext_s;
    logic [31:0]            en_ext_s;
    logic                   cur_pend_s;
    logic                   cur_en_s;
    logic                   iack_ok_s;
    logic                   eoi_wr_s;
    logic                   unused_addr_s;

    // A new access is taken only when no ack is outstanding, so a strobe held
    // through the ack cycle is not seen twice
    assign access_s   = bus.i_stb & ~ack_r;
    assign wr_s       = access_s & bus.i_rw;
    assign rd_s       = access_s & ~bus.i_rw;
    assign word_s     = bus.i_addr[MASK_LEN-1:2];
    assign hit_pend_s = (word_s == W_PEND);
    assign hit_stat_s = (word_s == W_STAT);
    assign hit_eoi_s  = (word_s == W_EOI);
    assign eoi_wr_s   = wr_s & hit_eoi_s;
    assign iack_ok_s  = (state_r == REQ) & i_iack;

    assign unused_addr_s = ^bus.i_addr[1:0];

    // Edge capture: only enabled lines latch, new edges win over any clear
    assign rise_s        = i_irq & ~irq_q_r & en_r;
    assign clr_s         = (wr_s & hit_pend_s) ? bus.i_dtw[NIRQ-1:0] : {NIRQ{1'b0}};
    assign pending_nxt_s = (pending_r & ~clr_s & ~ack_clr_s) | rise_s;
    assign active_s      = pending_r & en_r;

    // Zero-extended copies so the 5-bit vector can index them directly
    assign pend_ext_s = 32'(pending_r);
    assign en_ext_s   = 32'(en_r);
    assign cur_pend_s = pend_ext_s[vec_r];
    assign cur_en_s   = en_ext_s[vec_r];

    hs32_aict_prio #(
        .N (NIRQ)
    ) u_prio (
        .req   (active_s),
        .valid (win_valid_s),
        .idx   (win_idx_s)
    );

    // Per-entry write strobes, entry read mux, handler selects and iack clear mask
    always_comb begin
        entry_wr_s    = {NIRQ{1'b0}};
        entry_rdata_s = 32'd0;
        win_hnd_s     = {ENTRY_HND_W{1'b0}};
        cur_hnd_s     = {ENTRY_HND_W{1'b0}};
        ack_clr_s     = {NIRQ{1'b0}};
        for (int n = 0; n < NIRQ; n++) begin
            entry_wr_s[n] = wr_s & (word_s == WORD_W'(n + 1));
            entry_rdata_s = entry_rdata_s |
                            ((word_s == WORD_W'(n + 1)) ? entry_word(en_r[n], hnd_r[n]) : 32'd0);
            win_hnd_s     = win_hnd_s | ((win_idx_s == VEC_W'(n)) ? hnd_r[n] : {ENTRY_HND_W{1'b0}});
            cur_hnd_s     = cur_hnd_s | ((vec_r == VEC_W'(n)) ? hnd_r[n] : {ENTRY_HND_W{1'b0}});
            ack_clr_s[n]  = iack_ok_s & (vec_r == VEC_W'(n));
        end
    end

    // Read data mux; EOI and unmapped offsets read as zero
    always_comb begin
        rdata_s = 32'd0;
        if (hit_pend_s) begin
            rdata_s = pend_ext_s;
        end else if (hit_stat_s) begin
            rdata_s = {25'd0, (state_r == SERV), (state_r == REQ), vec_r};
        end else if (hit_eoi_s) begin
            rdata_s = 32'd0;
        end else begin
            rdata_s = entry_rdata_s;
        end
    end

    // Bus slave: one-cycle ack with registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_r <= 1'b0;
            dtr_r <= 32'd0;
        end else begin
            ack_r <= access_s;
            dtr_r <= rd_s ? rdata_s : 32'd0;
        end
    end

    // Entry register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r <= {NIRQ{1'b0}};
            for (int n = 0; n < NIRQ; n++) begin
                hnd_r[n] <= {ENTRY_HND_W{1'b0}};
            end
        end else begin
            for (int n = 0; n < NIRQ; n++) begin
                if (entry_wr_s[n]) begin
                    en_r[n]  <= bus.i_dtw[ENTRY_EN_BIT];
                    hnd_r[n] <= bus.i_dtw[ENTRY_HND_MSB:ENTRY_HND_LSB];
                end
            end
        end
    end

    // Interrupt line delay and pending register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q_r   <= {NIRQ{1'b0}};
            pending_r <= {NIRQ{1'b0}};
        end else begin
            irq_q_r   <= i_irq;
            pending_r <= pending_nxt_s;
        end
    end

    // Request / in-service FSM with registered core-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            int_r     <= 1'b0;
            vec_r     <= {VEC_W{1'b0}};
            handler_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        state_r   <= REQ;
                        int_r     <= 1'b1;
                        vec_r     <= win_idx_s;
                        handler_r <= handler_addr(win_hnd_s);
                    end else begin
                        int_r     <= 1'b0;
                        vec_r     <= {VEC_W{1'b0}};
                        handler_r <= 32'd0;
                    end
                end
                REQ: begin
                    if (i_iack) begin
                        state_r <= SERV;
                        int_r   <= 1'b0;
                    end else if (!cur_pend_s || !cur_en_s) begin
                        // Request withdrawn by software before the core took it
                        state_r   <= IDLE;
                        int_r     <= 1'b0;
                        vec_r     <= {VEC_W{1'b0}};
                        handler_r <= 32'd0;
                    end else begin
                        // Track entry rewrites while the request is outstanding
                        handler_r <= handler_addr(cur_hnd_s);
                    end
                end
                SERV: begin
                    if (eoi_wr_s) begin
                        state_r   <= IDLE;
                        vec_r     <= {VEC_W{1'b0}};
                        handler_r <= 32'd0;
                    end else begin
                        state_r <= SERV;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    int_r     <= 1'b0;
                    vec_r     <= {VEC_W{1'b0}};
                    handler_r <= 32'd0;
                end
            endcase
        end
    end

    assign bus.o_ack = ack_r;
    assign bus.o_dtr = dtr_r;
    assign o_int     = int_r;
    assign o_vec     = vec_r;
    assign o_handler = handler_r;

endmodule

// File: tb/tb_hs32_aict.sv
// tb_hs32_aict
// Directed self-checking bench for hs32_aict. Inputs are driven 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
module tb_hs32_aict;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] i_irq;
    logic        o_int;
    logic [4:0]  o_vec;
    logic [31:0] o_handler;
    logic        i_iack;

    int chk_cnt      = 0;
    int pass_cnt     = 0;
    int bus_timeouts = 0;

    logic [31:0] rd;
    int          lat;

    hs32_aict_if #(.MASK_LEN(8)) bus_if ();

    hs32_aict #(
        .NIRQ     (24),
        .MASK_LEN (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .i_irq     (i_irq),
        .o_int     (o_int),
        .o_vec     (o_vec),
        .o_handler (o_handler),
        .i_iack    (i_iack)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus access; lat = cycles from strobe to ack (-1 if none within budget)
    task automatic bus_xfer(input logic rw, input logic [7:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int latency);
        @(posedge clk); #1;
        bus_if.i_stb  = 1'b1;
        bus_if.i_rw   = rw;
        bus_if.i_addr = addr;
        bus_if.i_dtw  = wdata;
        rdata   = {32{1'bx}};
        latency = -1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (bus_if.o_ack === 1'b1) begin
                rdata   = bus_if.o_dtr;
                latency = k;
                break;
            end
        end
        if (latency < 0) bus_timeouts++;
        @(posedge clk); #1;
        bus_if.i_stb  = 1'b0;
        bus_if.i_rw   = 1'b0;
        bus_if.i_addr = 8'h00;
        bus_if.i_dtw  = 32'd0;
    endtask

    task automatic pulse_iack();
        @(posedge clk); #1;
        i_iack = 1'b1;
        @(posedge clk); #1;
        i_iack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({o_int, o_vec, o_handler} !== 38'd0)
            $display("FAIL reset_core_outs: got int=%0b vec=%0d hnd=%h want 0", o_int, o_vec, o_handler);
        else pass_cnt++;
        chk_cnt++;
        if ({bus_if.o_ack, bus_if.o_dtr} !== 33'd0)
            $display("FAIL reset_bus_outs: got ack=%0b dtr=%h want 0", bus_if.o_ack, bus_if.o_dtr);
        else pass_cnt++;
        reset = 1'b1;
        // Strobe held for three cycles: ack, gap, then a second ack
        @(posedge clk); #1;
        bus_if.i_stb  = 1'b1;
        bus_if.i_rw   = 1'b0;
        bus_if.i_addr = 8'h04;
        @(negedge clk);
        chk_cnt++;
        if (bus_if.o_ack !== 1'b0) $display("FAIL ack_early: got %0b want 0", bus_if.o_ack);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus_if.o_ack !== 1'b1) $display("FAIL ack_t1: got %0b want 1", bus_if.o_ack);
        else pass_cnt++;
        chk_cnt++;
        if (bus_if.o_dtr !== 32'd0) $display("FAIL entry0_reset: got %h want 00000000", bus_if.o_dtr);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus_if.o_ack !== 1'b0) $display("FAIL ack_pulse: got %0b want 0", bus_if.o_ack);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus_if.o_ack !== 1'b1) $display("FAIL ack_rearm: got %0b want 1", bus_if.o_ack);
        else pass_cnt++;
        @(posedge clk); #1;
        bus_if.i_stb = 1'b0;
        bus_xfer(1'b0, 8'h04, 32'd0, rd, lat);
        chk_cnt++;
        if (lat !== 1) $display("FAIL read_latency: got %0d want 1", lat);
        else pass_cnt++;
    endtask

    task automatic test_fire_one();
        bus_xfer(1'b1, 8'h0C, 32'h0000_1001, rd, lat);
        i_irq[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if (o_int !== 1'b0) $display("FAIL fire_int_t1: got %0b want 0", o_int);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (o_int !== 1'b1) $display("FAIL fire_int_t2: got %0b want 1", o_int);
        else pass_cnt++;
        chk_cnt++;
        if (o_vec !== 5'd2) $display("FAIL fire_vec: got %0d want 2", o_vec);
        else pass_cnt++;
        chk_cnt++;
        if (o_handler !== 32'h0000_1000) $display("FAIL fire_handler: got %h want 00001000", o_handler);
        else pass_cnt++;
        pulse_iack();
        @(negedge clk);
        chk_cnt++;
        if (o_int !== 1'b0) $display("FAIL iack_int: got %0b want 0", o_int);
        else pass_cnt++;
        bus_xfer(1'b0, 8'h70, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL iack_pending: got %h want 00000000", rd);
        else pass_cnt++;
        bus_xfer(1'b0, 8'h74, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'h0000_0042) $display("FAIL serv_status: got %h want 00000042", rd);
        else pass_cnt++;
        bus_xfer(1'b1, 8'h78, 32'h1234_5678, rd, lat);
        bus_xfer(1'b0, 8'h74, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL eoi_status: got %h want 00000000", rd);
        else pass_cnt++;
        i_irq[2] = 1'b0;
    endtask

    task automatic test_priority();
        bus_xfer(1'b1, 8'h10, 32'h0000_2003, rd, lat);
        bus_xfer(1'b1, 8'h18, 32'h0000_3001, rd, lat);
        bus_xfer(1'b0, 8'h10, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'h0000_2001) $display("FAIL entry_bit1: got %h want 00002001", rd);
        else pass_cnt++;
        i_irq[3] = 1'b1;
        i_irq[5] = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({o_int, o_vec} !== {1'b1, 5'd3}) $display("FAIL prio_first: got int=%0b vec=%0d want int=1 vec=3", o_int, o_vec);
        else pass_cnt++;
        chk_cnt++;
        if (o_handler !== 32'h0000_2000) $display("FAIL prio_handler3: got %h want 00002000", o_handler);
        else pass_cnt++;
        pulse_iack();
        bus_xfer(1'b1, 8'h78, 32'd0, rd, lat);
        @(negedge clk);
        chk_cnt++;
        if ({o_int, o_vec} !== {1'b1, 5'd5}) $display("FAIL prio_second: got int=%0b vec=%0d want int=1 vec=5", o_int, o_vec);
        else pass_cnt++;
        chk_cnt++;
        if (o_handler !== 32'h0000_3000) $display("FAIL prio_handler5: got %h want 00003000", o_handler);
        else pass_cnt++;
        pulse_iack();
        bus_xfer(1'b1, 8'h78, 32'd0, rd, lat);
        i_irq[3] = 1'b0;
        i_irq[5] = 1'b0;
        bus_xfer(1'b0, 8'h74, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL prio_idle_status: got %h want 00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_disabled_line();
        i_irq[7] = 1'b1;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (o_int !== 1'b0) $display("FAIL disabled_int: got %0b want 0", o_int);
        else pass_cnt++;
        bus_xfer(1'b0, 8'h70, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL disabled_pending: got %h want 00000000", rd);
        else pass_cnt++;
        i_irq[7] = 1'b0;
    endtask

    task automatic test_withdraw();
        bus_xfer(1'b1, 8'h14, 32'h0000_4001, rd, lat);
        i_irq[4] = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({o_int, o_vec} !== {1'b1, 5'd4}) $display("FAIL withdraw_req: got int=%0b vec=%0d want int=1 vec=4", o_int, o_vec);
        else pass_cnt++;
        bus_xfer(1'b1, 8'h70, 32'h0000_0010, rd, lat);
        @(negedge clk);
        chk_cnt++;
        if (o_int !== 1'b0) $display("FAIL withdraw_int: got %0b want 0", o_int);
        else pass_cnt++;
        pulse_iack();
        @(negedge clk);
        chk_cnt++;
        if (o_int !== 1'b0) $display("FAIL withdraw_iack_int: got %0b want 0", o_int);
        else pass_cnt++;
        bus_xfer(1'b0, 8'h74, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL withdraw_status: got %h want 00000000", rd);
        else pass_cnt++;
        i_irq[4] = 1'b0;
    endtask

    task automatic test_unmapped();
        bus_xfer(1'b0, 8'h00, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL read_off00: got %h want 00000000", rd);
        else pass_cnt++;
        bus_xfer(1'b1, 8'h7C, 32'hFFFF_FFFF, rd, lat);
        chk_cnt++;
        if (lat !== 1) $display("FAIL unmapped_write_ack: got latency %0d want 1", lat);
        else pass_cnt++;
        bus_xfer(1'b0, 8'h7C, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL read_off7c: got %h want 00000000", rd);
        else pass_cnt++;
        bus_xfer(1'b1, 8'h74, 32'hFFFF_FFFF, rd, lat);
        bus_xfer(1'b0, 8'h74, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL status_ro: got %h want 00000000", rd);
        else pass_cnt++;
        bus_xfer(1'b1, 8'h60, 32'hFFFF_FFFF, rd, lat);
        bus_xfer(1'b0, 8'h60, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'hFFFF_FFFD) $display("FAIL last_entry: got %h want fffffffd", rd);
        else pass_cnt++;
        bus_xfer(1'b1, 8'h64, 32'hFFFF_FFFF, rd, lat);
        bus_xfer(1'b0, 8'h64, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL past_last_entry: got %h want 00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_set_wins_and_reset();
        bus_xfer(1'b1, 8'h04, 32'h0000_5001, rd, lat);
        // W1C of bit 0 in the same cycle as a new edge on line 0
        @(posedge clk); #1;
        bus_if.i_stb  = 1'b1;
        bus_if.i_rw   = 1'b1;
        bus_if.i_addr = 8'h70;
        bus_if.i_dtw  = 32'h0000_0001;
        i_irq[0]      = 1'b1;
        @(posedge clk); #1;
        bus_if.i_stb  = 1'b0;
        bus_if.i_rw   = 1'b0;
        bus_if.i_dtw  = 32'd0;
        bus_xfer(1'b0, 8'h70, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'h0000_0001) $display("FAIL set_wins: got %h want 00000001", rd);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({o_int, o_vec, o_handler} !== {1'b1, 5'd0, 32'h0000_5000})
            $display("FAIL line0_req: got int=%0b vec=%0d hnd=%h want int=1 vec=0 hnd=00005000", o_int, o_vec, o_handler);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        chk_cnt++;
        if ({o_int, o_vec, o_handler, bus_if.o_ack, bus_if.o_dtr} !== 71'd0)
            $display("FAIL midreset_outs: got int=%0b vec=%0d hnd=%h ack=%0b dtr=%h want 0",
                     o_int, o_vec, o_handler, bus_if.o_ack, bus_if.o_dtr);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        i_irq = 24'd0;
        bus_xfer(1'b0, 8'h70, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL midreset_pending: got %h want 00000000", rd);
        else pass_cnt++;
        bus_xfer(1'b0, 8'h04, 32'd0, rd, lat);
        chk_cnt++;
        if (rd !== 32'd0) $display("FAIL midreset_entry0: got %h want 00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_bus_health();
        chk_cnt++;
        if (bus_timeouts !== 0) $display("FAIL bus_timeouts: got %0d want 0", bus_timeouts);
        else pass_cnt++;
    endtask

    initial begin
        reset         = 1'b0;
        i_irq         = 24'd0;
        i_iack        = 1'b0;
        bus_if.i_stb  = 1'b0;
        bus_if.i_rw   = 1'b0;
        bus_if.i_addr = 8'h00;
        bus_if.i_dtw  = 32'd0;
        test_reset();
        test_fire_one();
        test_priority();
        test_disabled_line();
        test_withdraw();
        test_unmapped();
        test_set_wins_and_reset();
        test_bus_health();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
